// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate scheduler.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECIDE = 2'd1,
      ISSUE  = 2'd2,
      SETTLE = 2'd3
   } state_t;

   typedef enum logic {
      EXIT  = 1'b0,
      ENTRY = 1'b1
   } gate_t;

   localparam int unsigned TOTAL_SPOTS = 700;
   localparam int unsigned UNI_SPOTS   = 100;
   localparam int unsigned COUNT_W     = 10;
   localparam int unsigned DENY_W      = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any_valid
);

   logic [IW-1:0] cand;

   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IW'((32'(ptr) + i) % N);
         if (!any_valid && req[cand]) begin
            any_valid   = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Serialises gate entry/exit requests into single-cycle occupancy events,
// checking each against counter status and settling before the next pick.
module parking_gate_scheduler #(
   parameter int unsigned NUM_ENTRY     = 2,
   parameter int unsigned NUM_EXIT      = 2,
   parameter int unsigned TOTAL_SPOTS   = parking_pkg::TOTAL_SPOTS,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_ENTRY-1:0] entry_req,
   input  logic [NUM_ENTRY-1:0] entry_is_uni,
   input  logic [NUM_EXIT-1:0]  exit_req,
   input  logic [NUM_EXIT-1:0]  exit_is_uni,
   output logic [NUM_ENTRY-1:0] entry_grant,
   output logic [NUM_ENTRY-1:0] entry_deny,
   output logic [NUM_EXIT-1:0]  exit_grant,
   output logic [NUM_EXIT-1:0]  exit_deny,
   input  logic [9:0]           parked_car,
   input  logic [9:0]           uni_parked_car,
   input  logic [9:0]           vacated_space,
   input  logic [9:0]           uni_vacated_space,
   output logic                 car_entered,
   output logic                 is_uni_car_entered,
   output logic                 car_exited,
   output logic                 is_uni_car_exited,
   output logic                 busy,
   output logic [15:0]          deny_count
);
   import parking_pkg::*;

   localparam int unsigned NREQ  = NUM_EXIT + NUM_ENTRY;
   localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [9:0]  SPOTS = 10'(TOTAL_SPOTS);

   logic [NREQ-1:0] req_all;
   logic [NREQ-1:0] cls_all;
   logic [NREQ-1:0] arb_grant;
   logic [PW-1:0]   arb_idx;
   logic            arb_any;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [NREQ-1:0] win_oh;
   gate_t           win_type;
   logic            win_uni;
   logic [2:0]      settle_cnt;
   logic [15:0]     deny_cnt;
   logic            decide_ok_c;

   assign req_all    = {entry_req, exit_req};
   assign cls_all    = {entry_is_uni, exit_is_uni};
   assign deny_count = deny_cnt;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req       (req_all),
      .ptr       (ptr),
      .grant     (arb_grant),
      .idx       (arb_idx),
      .any_valid (arb_any)
   );

   // Admission/exit validity against the counter status; vacancy above capacity means underflow.
   always_comb begin
      decide_ok_c = 1'b0;
      if (win_type == ENTRY) begin
         if (win_uni) decide_ok_c = (uni_vacated_space != 10'd0) && (parked_car < SPOTS);
         else         decide_ok_c = (vacated_space != 10'd0) && (vacated_space <= SPOTS)
                                    && (parked_car < SPOTS);
      end else begin
         if (win_uni) decide_ok_c = (uni_parked_car != 10'd0);
         else         decide_ok_c = (parked_car > uni_parked_car);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         ptr                <= '0;
         win_oh             <= '0;
         win_type           <= EXIT;
         win_uni            <= 1'b0;
         settle_cnt         <= '0;
         deny_cnt           <= '0;
         busy               <= 1'b0;
         entry_grant        <= '0;
         entry_deny         <= '0;
         exit_grant         <= '0;
         exit_deny          <= '0;
         car_entered        <= 1'b0;
         is_uni_car_entered <= 1'b0;
         car_exited         <= 1'b0;
         is_uni_car_exited  <= 1'b0;
      end else begin
         entry_grant        <= '0;
         entry_deny         <= '0;
         exit_grant         <= '0;
         exit_deny          <= '0;
         car_entered        <= 1'b0;
         is_uni_car_entered <= 1'b0;
         car_exited         <= 1'b0;
         is_uni_car_exited  <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_any) begin
                  win_oh   <= arb_grant;
                  win_type <= (arb_idx >= PW'(NUM_EXIT)) ? ENTRY : EXIT;
                  win_uni  <= cls_all[arb_idx];
                  ptr      <= (arb_idx == PW'(NREQ - 1)) ? '0 : PW'(arb_idx + 1'b1);
                  busy     <= 1'b1;
                  state    <= DECIDE;
               end
            end
            // Decision is registered straight into the ack/event outputs seen during ISSUE.
            DECIDE: begin
               state <= ISSUE;
               if (decide_ok_c) begin
                  if (win_type == ENTRY) begin
                     entry_grant        <= win_oh[NREQ-1:NUM_EXIT];
                     car_entered        <= 1'b1;
                     is_uni_car_entered <= win_uni;
                  end else begin
                     exit_grant        <= win_oh[NUM_EXIT-1:0];
                     car_exited        <= 1'b1;
                     is_uni_car_exited <= win_uni;
                  end
               end else begin
                  if (win_type == ENTRY) entry_deny <= win_oh[NREQ-1:NUM_EXIT];
                  else                   exit_deny  <= win_oh[NUM_EXIT-1:0];
                  if (deny_cnt != 16'hFFFF) deny_cnt <= deny_cnt + 16'd1;
               end
            end
            ISSUE: begin
               settle_cnt <= '0;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == 3'(SETTLE_CYCLES - 1)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  settle_cnt <= settle_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler with hand-computed expectations.
module tb_parking_gate_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  entry_req, entry_is_uni, exit_req, exit_is_uni;
   logic [1:0]  entry_grant, entry_deny, exit_grant, exit_deny;
   logic [9:0]  parked_car, uni_parked_car, vacated_space, uni_vacated_space;
   logic        car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
   logic        busy;
   logic [15:0] deny_count;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] exp_deny;

   logic [1:0]  t_eg, t_ed, t_xg, t_xd;
   logic        t_ce, t_cue, t_cx, t_cux;
   int          t_busy, t_events;

   always #5 clk = ~clk;

   parking_gate_scheduler dut (
      .clk                (clk),
      .reset              (reset),
      .entry_req          (entry_req),
      .entry_is_uni       (entry_is_uni),
      .exit_req           (exit_req),
      .exit_is_uni        (exit_is_uni),
      .entry_grant        (entry_grant),
      .entry_deny         (entry_deny),
      .exit_grant         (exit_grant),
      .exit_deny          (exit_deny),
      .parked_car         (parked_car),
      .uni_parked_car     (uni_parked_car),
      .vacated_space      (vacated_space),
      .uni_vacated_space  (uni_vacated_space),
      .car_entered        (car_entered),
      .is_uni_car_entered (is_uni_car_entered),
      .car_exited         (car_exited),
      .is_uni_car_exited  (is_uni_car_exited),
      .busy               (busy),
      .deny_count         (deny_count)
   );

   // Drive one request pattern; capture outputs in the ack cycle (2nd cycle after sampling edge).
   task automatic one_txn(input logic [1:0] er, eu, xr, xu);
      @(negedge clk);
      entry_req = er; entry_is_uni = eu; exit_req = xr; exit_is_uni = xu;
      t_eg = '0; t_ed = '0; t_xg = '0; t_xd = '0;
      t_ce = 1'b0; t_cue = 1'b0; t_cx = 1'b0; t_cux = 1'b0;
      t_busy = 0; t_events = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) t_busy++;
         if ((entry_grant | entry_deny | exit_grant | exit_deny) != 2'b00) t_events++;
         if (k == 2) begin
            t_eg = entry_grant; t_ed = entry_deny; t_xg = exit_grant; t_xd = exit_deny;
            t_ce = car_entered; t_cue = is_uni_car_entered;
            t_cx = car_exited;  t_cux = is_uni_car_exited;
            entry_req = '0; exit_req = '0; entry_is_uni = '0; exit_is_uni = '0;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_deny = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      entry_req = '0; entry_is_uni = '0; exit_req = '0; exit_is_uni = '0;
      parked_car = '0; uni_parked_car = '0; vacated_space = 10'd700; uni_vacated_space = 10'd500;
      exp_deny = '0;
      repeat (3) @(negedge clk);
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else n_pass++;
      n_checks++;
      if (deny_count !== 16'd0) $display("FAIL reset_deny_count: got %0d want 0", deny_count);
      else n_pass++;
      n_checks++;
      if ({entry_grant, entry_deny, exit_grant, exit_deny, car_entered, is_uni_car_entered,
           car_exited, is_uni_car_exited} !== 12'd0)
         $display("FAIL reset_outputs: got %b want 0", {entry_grant, entry_deny, exit_grant,
                  exit_deny, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited});
      else n_pass++;
      n_checks++;
      reset = 1'b0;
   endtask

   task automatic test_uni_entry();
      one_txn(2'b01, 2'b01, 2'b00, 2'b00);
      if (t_eg !== 2'b01) $display("FAIL uni_entry_grant: got %b want 01", t_eg); else n_pass++;
      n_checks++;
      if (t_ed !== 2'b00) $display("FAIL uni_entry_deny: got %b want 00", t_ed); else n_pass++;
      n_checks++;
      if ({t_ce, t_cue} !== 2'b11) $display("FAIL uni_entry_event: got %b want 11", {t_ce, t_cue});
      else n_pass++;
      n_checks++;
      if (t_cx !== 1'b0) $display("FAIL uni_entry_no_exit: got %b want 0", t_cx); else n_pass++;
      n_checks++;
      if (t_busy != 4) $display("FAIL uni_entry_busy_cycles: got %0d want 4", t_busy); else n_pass++;
      n_checks++;
      if (t_events != 1) $display("FAIL uni_entry_pulse_len: got %0d want 1", t_events); else n_pass++;
      n_checks++;
   endtask

   task automatic test_full_lot();
      vacated_space = 10'd0;
      one_txn(2'b01, 2'b00, 2'b00, 2'b00);
      exp_deny = exp_deny + 16'd1;
      if (t_ed !== 2'b01 || t_eg !== 2'b00)
         $display("FAIL full_deny_ack: got grant %b deny %b want 00/01", t_eg, t_ed);
      else n_pass++;
      n_checks++;
      if (t_ce !== 1'b0) $display("FAIL full_no_event: got %b want 0", t_ce); else n_pass++;
      n_checks++;
      if (deny_count !== exp_deny) $display("FAIL full_deny_count: got %0d want %0d", deny_count, exp_deny);
      else n_pass++;
      n_checks++;

      vacated_space = 10'd1020;
      one_txn(2'b01, 2'b00, 2'b00, 2'b00);
      exp_deny = exp_deny + 16'd1;
      if (t_ed !== 2'b01) $display("FAIL underflow_deny: got %b want 01", t_ed); else n_pass++;
      n_checks++;
      if (deny_count !== exp_deny) $display("FAIL underflow_deny_count: got %0d want %0d", deny_count, exp_deny);
      else n_pass++;
      n_checks++;

      vacated_space = 10'd700;
      one_txn(2'b10, 2'b00, 2'b00, 2'b00);
      if (t_eg !== 2'b10 || {t_ce, t_cue} !== 2'b10)
         $display("FAIL vac_at_cap_grant: got grant %b ev %b want 10/10", t_eg, {t_ce, t_cue});
      else n_pass++;
      n_checks++;

      parked_car = 10'd700;
      one_txn(2'b01, 2'b01, 2'b00, 2'b00);
      exp_deny = exp_deny + 16'd1;
      if (t_ed !== 2'b01 || t_ce !== 1'b0)
         $display("FAIL parked_at_cap_deny: got deny %b ev %b want 01/0", t_ed, t_ce);
      else n_pass++;
      n_checks++;
      if (deny_count !== exp_deny) $display("FAIL parked_cap_deny_count: got %0d want %0d", deny_count, exp_deny);
      else n_pass++;
      n_checks++;
      parked_car = 10'd0;
   endtask

   task automatic test_exit();
      parked_car = 10'd3; uni_parked_car = 10'd3;
      one_txn(2'b00, 2'b00, 2'b10, 2'b00);
      exp_deny = exp_deny + 16'd1;
      if (t_xd !== 2'b10 || t_xg !== 2'b00)
         $display("FAIL invalid_exit_ack: got grant %b deny %b want 00/10", t_xg, t_xd);
      else n_pass++;
      n_checks++;
      if (t_cx !== 1'b0) $display("FAIL invalid_exit_no_event: got %b want 0", t_cx); else n_pass++;
      n_checks++;

      one_txn(2'b00, 2'b00, 2'b01, 2'b01);
      if (t_xg !== 2'b01 || {t_cx, t_cux} !== 2'b11)
         $display("FAIL uni_exit_grant: got grant %b ev %b want 01/11", t_xg, {t_cx, t_cux});
      else n_pass++;
      n_checks++;

      uni_parked_car = 10'd0;
      one_txn(2'b00, 2'b00, 2'b01, 2'b01);
      exp_deny = exp_deny + 16'd1;
      if (t_xd !== 2'b01 || t_cx !== 1'b0)
         $display("FAIL uni_exit_empty_deny: got deny %b ev %b want 01/0", t_xd, t_cx);
      else n_pass++;
      n_checks++;

      parked_car = 10'd4; uni_parked_car = 10'd3;
      one_txn(2'b00, 2'b00, 2'b10, 2'b00);
      if (t_xg !== 2'b10 || {t_cx, t_cux} !== 2'b10)
         $display("FAIL gen_exit_grant: got grant %b ev %b want 10/10", t_xg, {t_cx, t_cux});
      else n_pass++;
      n_checks++;
      if (deny_count !== exp_deny) $display("FAIL exit_deny_count: got %0d want %0d", deny_count, exp_deny);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] got_ack [8];
      int         got_k [8];
      int         n_acks = 0;
      int         both = 0;
      for (int i = 0; i < 8; i++) begin got_ack[i] = '0; got_k[i] = 0; end
      apply_reset();
      parked_car = 10'd10; uni_parked_car = 10'd5; vacated_space = 10'd600; uni_vacated_space = 10'd100;
      @(negedge clk);
      entry_req = 2'b11; entry_is_uni = 2'b11; exit_req = 2'b11; exit_is_uni = 2'b11;
      for (int k = 1; k <= 28; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (car_entered && car_exited) both++;
         if ({entry_grant, exit_grant} != 4'b0000 && n_acks < 8) begin
            got_ack[n_acks] = {entry_grant, exit_grant};
            got_k[n_acks]   = k;
            n_acks++;
         end
         if (k == 22) begin entry_req = '0; exit_req = '0; end
      end
      if (n_acks != 5) $display("FAIL rr_ack_count: got %0d want 5", n_acks); else n_pass++;
      n_checks++;
      for (int i = 0; i < 5; i++) begin
         if (got_ack[i] !== exp_order[i])
            $display("FAIL rr_order[%0d]: got %b want %b", i, got_ack[i], exp_order[i]);
         else n_pass++;
         n_checks++;
         if (got_k[i] != 2 + 5 * i)
            $display("FAIL rr_timing[%0d]: got cycle %0d want %0d", i, got_k[i], 2 + 5 * i);
         else n_pass++;
         n_checks++;
      end
      if (both != 0) $display("FAIL rr_both_events: got %0d want 0", both); else n_pass++;
      n_checks++;
      entry_is_uni = '0; exit_is_uni = '0;
   endtask

   task automatic test_reset_mid_op();
      int pulses = 0;
      @(negedge clk);
      entry_req = 2'b01; entry_is_uni = 2'b01;
      @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b1) $display("FAIL midrst_in_decide: got busy %b want 1", busy); else n_pass++;
      n_checks++;
      reset = 1'b1;
      #1;
      if (busy !== 1'b0 || deny_count !== 16'd0)
         $display("FAIL midrst_state: got busy %b deny %0d want 0/0", busy, deny_count);
      else n_pass++;
      n_checks++;
      if ({entry_grant, entry_deny, exit_grant, exit_deny, car_entered, car_exited} !== 10'd0)
         $display("FAIL midrst_outputs: got %b want 0", {entry_grant, entry_deny, exit_grant,
                  exit_deny, car_entered, car_exited});
      else n_pass++;
      n_checks++;
      entry_req = '0; entry_is_uni = '0;
      exp_deny = '0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy || car_entered || car_exited || (entry_grant | entry_deny) != 2'b00) pulses++;
      end
      if (pulses != 0) $display("FAIL midrst_no_pulse: got %0d active cycles want 0", pulses); else n_pass++;
      n_checks++;
      one_txn(2'b11, 2'b11, 2'b11, 2'b11);
      if (t_xg !== 2'b01 || t_eg !== 2'b00)
         $display("FAIL midrst_ptr_zero: got exit %b entry %b want 01/00", t_xg, t_eg);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_deny_saturation();
      logic [15:0] exp_seq [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
      vacated_space = 10'd0;
      @(negedge clk);
      force dut.deny_cnt = 16'hFFFD;
      @(negedge clk);
      release dut.deny_cnt;
      for (int i = 0; i < 3; i++) begin
         one_txn(2'b01, 2'b00, 2'b00, 2'b00);
         if (t_ed !== 2'b01) $display("FAIL sat_deny_ack[%0d]: got %b want 01", i, t_ed); else n_pass++;
         n_checks++;
         if (deny_count !== exp_seq[i])
            $display("FAIL sat_deny_count[%0d]: got %h want %h", i, deny_count, exp_seq[i]);
         else n_pass++;
         n_checks++;
      end
      vacated_space = 10'd700;
   endtask

   initial begin
      test_reset();
      test_uni_entry();
      test_full_lot();
      test_exit();
      test_fairness();
      test_reset_mid_op();
      test_deny_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
